// File: rtl/gen_reg_arb.sv
// gen_reg_arb: round-robin access controller for the general register file.
// Serializes read/write commands from NUM_REQ requesters onto a single
// register-file port, checks address and lane select, and returns read data
// or an error on a per-requester response handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester command handshake (ready one-hot or zero)
//   req_we/sel/addr/wdata  per-requester command fields, packed by requester
//   resp_valid/ready  per-requester response handshake (valid one-hot or zero)
//   resp_rdata/err    shared response payload
//   rf_en/we/addr_sel/addr/wdata  registered register-file port
//   rf_rdata          register-file read data, valid the cycle after rf_en
//
// Build option: GEN_REG_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
// highest) instead of the default round-robin arbiter.
module gen_reg_arb #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_we,
  input  logic [2*NUM_REQ-1:0]    req_sel,
  input  logic [10*NUM_REQ-1:0]   req_addr,
  input  logic [20*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [19:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    rf_en,
  output logic                    rf_we,
  output logic [1:0]              rf_addr_sel,
  output logic [9:0]              rf_addr,
  output logic [19:0]             rf_wdata,
  input  logic [19:0]             rf_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic [19:0] wdata;
  } cmd_t;

  cmd_t [NUM_REQ-1:0] req_cmd;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_cmd[i] = {req_we[i], req_sel[2*i +: 2], req_addr[10*i +: 10],
                           req_wdata[20*i +: 20]};
    end
  endgenerate

  // ---------------------------------------------------------------- arbiter
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;

`ifdef GEN_REG_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_idx = '0;
    // descending scan so the lowest asserted index is written last
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req_valid[i]) gnt_idx = IW'(i);
    gnt_any = |req_valid;
  end
`else
  logic [IW-1:0] ptr;
  int            rr_best;

  // winner = asserted requester with the smallest distance ahead of ptr
  always_comb begin
    gnt_idx = '0;
    rr_best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_valid[j] && ((j - int'(ptr) + NUM_REQ) % NUM_REQ) < rr_best) begin
        rr_best = (j - int'(ptr) + NUM_REQ) % NUM_REQ;
        gnt_idx = IW'(j);
      end
    end
    gnt_any = |req_valid;
  end
`endif

  cmd_t cur_cmd;
  logic cmd_bad;

  assign cur_cmd = req_cmd[gnt_idx];
  assign cmd_bad = (cur_cmd.addr >= 10'(NUM_REGS)) || (cur_cmd.sel == 2'b11);

  // ---------------------------------------------------------------- FSM
  state_t        state, state_nxt;
  logic          hs;
  logic [IW-1:0] idx_q;
  logic [1:0]    sel_q;
  logic          we_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    hs         = 1'b0;
    case (state)
      IDLE: if (gnt_any) begin
        // grant only ever goes to an asserted valid, so ready implies handshake
        req_ready = NUM_REQ'(1) << gnt_idx;
        hs        = 1'b1;
        state_nxt = cmd_bad ? RESP : ISSUE;
      end
      ISSUE: state_nxt = CAPT;
      CAPT:  state_nxt = RESP;
      RESP: begin
        resp_valid = NUM_REQ'(1) << idx_q;
        if (resp_ready[idx_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef GEN_REG_ARB_FIXED_PRIO_EN
  // errored grants advance the pointer too
  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (hs) ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      rf_en       <= 1'b0;
      rf_we       <= 1'b0;
      rf_addr_sel <= '0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
    end else begin
      rf_en <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          idx_q      <= gnt_idx;
          sel_q      <= cur_cmd.sel;
          we_q       <= cur_cmd.we;
          resp_err   <= cmd_bad;
          resp_rdata <= '0;          // writes and errors return zero data
          if (!cmd_bad) begin
            rf_en       <= 1'b1;
            rf_we       <= cur_cmd.we;
            rf_addr_sel <= cur_cmd.sel;
            rf_addr     <= cur_cmd.addr;
            // lane writes replicate the 10-bit payload onto both halves
            rf_wdata    <= (cur_cmd.sel == 2'b00) ? cur_cmd.wdata
                                                  : {cur_cmd.wdata[9:0], cur_cmd.wdata[9:0]};
          end
        end
        CAPT: if (!we_q) begin
          case (sel_q)
            2'b01:   resp_rdata <= {10'b0, rf_rdata[19:10]};
            2'b10:   resp_rdata <= {10'b0, rf_rdata[9:0]};
            default: resp_rdata <= rf_rdata;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_reg_arb.sv
module tb_gen_reg_arb;
  localparam int N  = 3;
  localparam int NR = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0, req_ready, req_we = '0;
  logic [2*N-1:0]   req_sel = '0;
  logic [10*N-1:0]  req_addr = '0;
  logic [20*N-1:0]  req_wdata = '0;
  logic [N-1:0]     resp_valid, resp_ready = '1;
  logic [19:0]      resp_rdata, rf_wdata;
  logic [19:0]      rf_rdata = '0;
  logic             resp_err, rf_en, rf_we;
  logic [1:0]       rf_addr_sel;
  logic [9:0]       rf_addr;

  gen_reg_arb #(.NUM_REQ(N), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr_sel(rf_addr_sel),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // register file environment: lane writes take the matching half of rf_wdata
  logic [19:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (rf_en && int'(rf_addr) < NR) begin
      rf_rdata <= rf_mem[rf_addr[2:0]];
      if (rf_we) begin
        case (rf_addr_sel)
          2'b00: rf_mem[rf_addr[2:0]]        <= rf_wdata;
          2'b01: rf_mem[rf_addr[2:0]][19:10] <= rf_wdata[19:10];
          2'b10: rf_mem[rf_addr[2:0]][9:0]   <= rf_wdata[9:0];
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- model
  typedef struct {
    int          idx;
    logic [19:0] rdata;
    logic        err;
    int          hs_cyc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  logic [19:0] ref_regs [8];
  initial for (int i = 0; i < 8; i++) ref_regs[i] = '0;

  int cyc = 0, ptr_m = 0, rf_due = -1;
  bit busy = 1'b0, seen_first = 1'b0;
  logic [N-1:0] accepted = '0;
  int resp_count = 0, rf_en_cnt = 0, last_lat = 0;
  logic [19:0] last_rdata = '0, last_rf_wdata = '0, exp_rf_wdata = '0;
  logic [9:0]  exp_rf_addr = '0;
  logic [1:0]  last_rf_sel = '0, exp_rf_sel = '0;
  logic        last_err = 1'b0, exp_rf_we = 1'b0;

  function automatic int model_grant(input int p, input logic [N-1:0] v);
`ifdef GEN_REG_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (bit_at(v, i)) return i;
`else
    for (int k = 0; k < N; k++) if (bit_at(v, (p + k) % N)) return (p + k) % N;
`endif
    return 0;
  endfunction

  always @(posedge clk) cyc++;

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    logic [N-1:0] exp_rr, exp_rv, t;
    exp_t e;
    int g, a;
    logic we;
    logic [1:0] sel;
    logic [9:0] addr;
    logic [19:0] wd;
    if (rst) begin
      busy = 1'b0; ptr_m = 0; rf_due = -1; seen_first = 1'b0;
      sb.delete();
    end else begin
      exp_rr = '0;
      if (!busy && req_valid != '0) exp_rr = N'(1) << model_grant(ptr_m, req_valid);
      chk("req_ready", 32'(req_ready), 32'(exp_rr));

      chk("rf_en", 32'(rf_en), 32'(rf_due == cyc));
      if (rf_en) begin
        rf_en_cnt++;
        last_rf_wdata = rf_wdata;
        last_rf_sel   = rf_addr_sel;
        if (rf_due == cyc) begin
          chk("rf_we", 32'(rf_we), 32'(exp_rf_we));
          chk("rf_addr", 32'(rf_addr), 32'(exp_rf_addr));
          chk("rf_addr_sel", 32'(rf_addr_sel), 32'(exp_rf_sel));
          chk("rf_wdata", 32'(rf_wdata), 32'(exp_rf_wdata));
        end
      end

      exp_rv = '0;
      if (sb.size() > 0 && cyc >= sb[0].due) exp_rv = N'(1) << sb[0].idx;
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        chk("resp_rdata", 32'(resp_rdata), 32'(sb[0].rdata));
        chk("resp_err", 32'(resp_err), 32'(sb[0].err));
        if (!seen_first) begin
          seen_first = 1'b1;
          last_lat   = cyc - sb[0].hs_cyc;
        end
        if (bit_at(resp_ready, sb[0].idx)) begin
          last_rdata = resp_rdata;
          last_err   = resp_err;
          void'(sb.pop_front());
          busy = 1'b0; seen_first = 1'b0;
          resp_count++;
        end
      end

      if (exp_rr != '0 && req_ready == exp_rr) begin
        g    = model_grant(ptr_m, req_valid);
        t    = req_we >> g;
        we   = t[0];
        sel  = 2'(req_sel >> (2*g));
        addr = 10'(req_addr >> (10*g));
        wd   = 20'(req_wdata >> (20*g));
        a    = int'(addr[2:0]);
        e.idx = g; e.hs_cyc = cyc; e.rdata = '0;
        e.err = (int'(addr) >= NR) || (sel == 2'b11);
        e.due = e.err ? cyc + 1 : cyc + 3;
        if (!e.err) begin
          rf_due = cyc + 1;
          exp_rf_we = we; exp_rf_addr = addr; exp_rf_sel = sel;
          exp_rf_wdata = (sel == 2'b00) ? wd : {wd[9:0], wd[9:0]};
          if (we) begin
            if (sel == 2'b00)      ref_regs[a]        = wd;
            else if (sel == 2'b01) ref_regs[a][19:10] = wd[9:0];
            else                   ref_regs[a][9:0]   = wd[9:0];
          end else begin
            if (sel == 2'b00)      e.rdata = ref_regs[a];
            else if (sel == 2'b01) e.rdata = {10'b0, ref_regs[a][19:10]};
            else                   e.rdata = {10'b0, ref_regs[a][9:0]};
          end
        end
        sb.push_back(e);
        busy = 1'b1;
        ptr_m = (g + 1) % N;
        accepted |= N'(1) << g;
        grant_log.push_back(g);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic set_cmd(input int i, input bit we, input logic [1:0] sel,
                         input logic [9:0] addr, input logic [19:0] wd);
    req_we    = (req_we & ~(N'(1) << i)) | (N'(we) << i);
    req_sel[2*i +: 2]    = sel;
    req_addr[10*i +: 10] = addr;
    req_wdata[20*i +: 20] = wd;
    req_valid |= N'(1) << i;
  endtask

  task automatic drop(input int i);
    req_valid &= ~(N'(1) << i);
  endtask

  task automatic wait_accept(input int i);
    int t = 0;
    while (!bit_at(accepted, i) && t < 40) begin @(posedge clk); #1; t++; end
    if (!bit_at(accepted, i)) bound_fail("accept_timeout");
    accepted &= ~(N'(1) << i);
    drop(i);
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while (resp_count == n && t < 40) begin @(posedge clk); #1; t++; end
    if (resp_count == n) bound_fail("resp_timeout");
  endtask

  task automatic do_cmd(input int i, input bit we, input logic [1:0] sel,
                        input logic [9:0] addr, input logic [19:0] wd);
    int n = resp_count;
    set_cmd(i, we, sel, addr, wd);
    wait_accept(i);
    wait_resp(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, base, t, rc0, rfc;
    logic [19:0] rd0;
    logic e0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_rdata", 32'(resp_rdata), 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_rf_bus", 32'({rf_en, rf_we, rf_addr_sel, rf_addr}), 0);
    chk("rst_rf_wdata", 32'(rf_wdata), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // write then read back
    do_cmd(0, 1'b1, 2'b00, 10'd0, 20'hAAAAA);
    do_cmd(0, 1'b0, 2'b00, 10'd0, 20'h0);
    chk("rd0_data", 32'(last_rdata), 32'h000AAAAA);
    chk("rd0_err", 32'(last_err), 0);
    chk("rd0_latency", 32'(last_lat), 3);

    // lane access
    do_cmd(0, 1'b1, 2'b00, 10'd1, 20'hCCCCC);
    do_cmd(0, 1'b0, 2'b01, 10'd1, 20'h0);
    chk("lane_hi", 32'(last_rdata), 32'h00333);
    do_cmd(0, 1'b0, 2'b10, 10'd1, 20'h0);
    chk("lane_lo", 32'(last_rdata), 32'h000CC);
    do_cmd(0, 1'b1, 2'b10, 10'd1, 20'h0000F);
    chk("lane_wr_wdata", 32'(last_rf_wdata), 32'h03C0F);
    chk("lane_wr_sel", 32'(last_rf_sel), 32'h2);
    chk("lane_wr_rdata", 32'(last_rdata), 0);

    // errors
    rfc = rf_en_cnt;
    do_cmd(1, 1'b0, 2'b00, 10'd6, 20'h0);
    chk("err_addr_flag", 32'(last_err), 1);
    chk("err_addr_latency", 32'(last_lat), 1);
    chk("err_addr_rdata", 32'(last_rdata), 0);
    do_cmd(2, 1'b1, 2'b11, 10'd2, 20'h12345);
    chk("err_sel_flag", 32'(last_err), 1);
    chk("err_sel_latency", 32'(last_lat), 1);
    chk("err_no_rf_en", 32'(rf_en_cnt), 32'(rfc));

    // back-pressure: requester 0 holds off, others' ready bits must not matter
    resp_ready = 3'b110;
    rc0 = resp_count;
    set_cmd(0, 1'b0, 2'b00, 10'd1, 20'h0);
    wait_accept(0);
    set_cmd(1, 1'b0, 2'b00, 10'd0, 20'h0);
    t = 0;
    @(negedge clk);
    while (!resp_valid[0] && t < 20) begin @(negedge clk); t++; end
    if (!resp_valid[0]) bound_fail("bp_resp_timeout");
    rd0 = resp_rdata; e0 = resp_err;
    chk("bp_rdata", 32'(rd0), 32'h000CCC0F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(resp_valid), 32'h1);
      chk("bp_rdata_hold", 32'(resp_rdata), 32'(rd0));
      chk("bp_err_hold", 32'(resp_err), 32'(e0));
      chk("bp_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    drop(1);
    resp_ready = '1;
    wait_resp(rc0);
    chk("bp_consumed", 32'(resp_count - rc0), 1);

    // reset while the read sits in CAPT
    set_cmd(1, 1'b0, 2'b00, 10'd2, 20'h0);
    wait_accept(1);                 // now in ISSUE
    @(posedge clk); #1;             // now in CAPT
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    accepted = '0;
    cnt = 0;
    repeat (6) begin @(negedge clk); if (resp_valid != '0) cnt++; end
    chk("midrst_no_resp", 32'(cnt), 0);

    // arbitration with all requesters asserting continuously
    base = grant_log.size();
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 2'b00, 10'(i), 20'h0);
    t = 0;
    while (grant_log.size() < base + 6 && t < 100) begin @(posedge clk); #1; t++; end
    req_valid = '0;
    if (grant_log.size() < base + 6) bound_fail("arb_timeout");
    else begin
      for (int k = 0; k < 6; k++) begin
`ifdef GEN_REG_ARB_FIXED_PRIO_EN
        chk("arb_grant", 32'(grant_log[base + k]), 0);
`else
        chk("arb_grant", 32'(grant_log[base + k]), 32'(k % N));
`endif
      end
    end
    t = 0;
    while (sb.size() > 0 && t < 40) begin @(posedge clk); #1; t++; end
    accepted = '0;

    // randomized traffic
    base = resp_count;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [1:0] s;
        logic [9:0] ad;
        s  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ad = ($urandom_range(0, 9) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
        if (bit_at(accepted, i)) begin
          accepted &= ~(N'(1) << i);
          if ($urandom_range(0, 1) == 1) set_cmd(i, 1'($urandom), s, ad, 20'($urandom));
          else drop(i);
        end else if (!bit_at(req_valid, i)) begin
          if ($urandom_range(0, 3) == 0) set_cmd(i, 1'($urandom), s, ad, 20'($urandom));
        end else if ($urandom_range(0, 19) == 0) begin
          drop(i);
        end
      end
      resp_ready = N'($urandom);
      @(posedge clk); #1;
    end
    req_valid = '0;
    resp_ready = '1;
    t = 0;
    while (sb.size() > 0 && t < 40) begin @(posedge clk); #1; t++; end
    if (sb.size() > 0) bound_fail("drain_timeout");
    n = resp_count - base;
    chk("rand_progress", 32'(n >= 200), 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
